// File: rtl/ramen_order_sched.sv
// Session controller and round-robin order scheduler sharing one Ramen shop engine among NUM_REQ counters.
// Optional watchdog on the engine response enabled by defining RAMEN_SCHED_WDOG_EN.
module ramen_order_sched #(
  parameter int NUM_REQ     = 4,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   open_req,
  input  logic                   close_req,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [2*NUM_REQ-1:0]   req_type,
  input  logic [NUM_REQ-1:0]     req_portion,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic                   resp_success,
  output logic                   eng_in_valid,
  output logic                   eng_selling,
  output logic                   eng_portion,
  output logic [1:0]             eng_ramen_type,
  input  logic                   eng_out_valid_order,
  input  logic                   eng_success,
  input  logic                   eng_out_valid_tot,
  input  logic [14:0]            eng_total_gain,
  input  logic [27:0]            eng_sold_num,
  output logic                   busy,
  output logic                   day_done,
  output logic [14:0]            day_total_gain,
  output logic [27:0]            day_sold_num,
  output logic                   timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYCLES < 1 || WDOG_CYCLES > 255) begin : g_param_check
    $error("ramen_order_sched: NUM_REQ must be 2..8 and WDOG_CYCLES 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_ISSUE,
    S_WAIT,
    S_CLOSE,
    S_WAIT_TOT
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] win_idx;
  logic             close_pend;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_found;
  logic             in_session;

`ifdef RAMEN_SCHED_WDOG_EN
  localparam logic [7:0] WDOG_LAST = 8'(WDOG_CYCLES - 1);
  logic [7:0] wdog_cnt;
  logic       timeout_q;
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search: first pending counter at or after rr_ptr, wrapping to 0.
  always_comb begin
    int idx;
    arb_found = 1'b0;
    arb_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!arb_found && req_valid[idx]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(idx);
      end
    end
  end

  assign in_session = (state == S_ARB) || (state == S_ISSUE) || (state == S_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      rr_ptr         <= '0;
      close_pend     <= 1'b0;
      req_ready      <= '0;
      resp_valid     <= '0;
      resp_success   <= 1'b0;
      eng_in_valid   <= 1'b0;
      eng_selling    <= 1'b0;
      eng_portion    <= 1'b0;
      eng_ramen_type <= '0;
      busy           <= 1'b0;
      day_done       <= 1'b0;
      day_total_gain <= '0;
      day_sold_num   <= '0;
`ifdef RAMEN_SCHED_WDOG_EN
      wdog_cnt       <= '0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      req_ready  <= '0;
      resp_valid <= '0;
      day_done   <= 1'b0;
      // A close request is remembered until the arbiter next gets control.
      if (close_req && in_session) close_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (open_req) begin
            state       <= S_ARB;
            eng_selling <= 1'b1;
            busy        <= 1'b1;
            close_pend  <= 1'b0;
`ifdef RAMEN_SCHED_WDOG_EN
            timeout_q   <= 1'b0;
`endif
          end
        end

        S_ARB: begin
          if (close_pend || close_req) begin
            state      <= S_CLOSE;
            close_pend <= 1'b0;
          end else if (arb_found) begin
            state          <= S_ISSUE;
            win_idx        <= arb_idx;
            req_ready      <= onehot(arb_idx);
            eng_in_valid   <= 1'b1;
            eng_portion    <= req_portion[arb_idx];
            eng_ramen_type <= req_type[{arb_idx, 1'b0} +: 2];
          end
        end

        S_ISSUE: begin
          state          <= S_WAIT;
          eng_in_valid   <= 1'b0;
          eng_portion    <= 1'b0;
          eng_ramen_type <= '0;
          rr_ptr         <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
`ifdef RAMEN_SCHED_WDOG_EN
          wdog_cnt       <= '0;
`endif
        end

        S_WAIT: begin
          if (eng_out_valid_order) begin
            state        <= S_ARB;
            resp_valid   <= onehot(win_idx);
            resp_success <= eng_success;
          end
`ifdef RAMEN_SCHED_WDOG_EN
          // A silent engine is answered with a failure so the counter is not stranded.
          else if (wdog_cnt == WDOG_LAST) begin
            state        <= S_ARB;
            resp_valid   <= onehot(win_idx);
            resp_success <= 1'b0;
            timeout_q    <= 1'b1;
          end else begin
            wdog_cnt <= wdog_cnt + 8'd1;
          end
`endif
        end

        S_CLOSE: begin
          state       <= S_WAIT_TOT;
          eng_selling <= 1'b0;
        end

        S_WAIT_TOT: begin
          if (eng_out_valid_tot) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            day_done       <= 1'b1;
            day_total_gain <= eng_total_gain;
            day_sold_num   <= eng_sold_num;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
